// File: rtl/vram_port_ctrl_if.sv
// Port-A bundle of the VRAM controller: CPU load/store, fill-engine command and VRAM side.
interface vram_port_ctrl_if #(
  parameter int DATA = 8,
  parameter int ADDR = 13
);
  logic            cpu_req;
  logic            cpu_we;
  logic [ADDR-1:0] cpu_addr;
  logic [DATA-1:0] cpu_wdata;
  logic            cpu_ack;
  logic [DATA-1:0] cpu_rdata;
  logic            cmd_valid;
  logic            cmd_op;
  logic [DATA-1:0] cmd_fill;
  logic            cmd_ready;
  logic            busy;
  logic            done;
  logic            vram_wr;
  logic [ADDR-1:0] vram_addr;
  logic [DATA-1:0] vram_din;
  logic [DATA-1:0] vram_dout;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cmd_valid, cmd_op, cmd_fill, vram_dout,
    input  cpu_ack, cpu_rdata, cmd_ready, busy, done, vram_wr, vram_addr, vram_din
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cmd_valid, cmd_op, cmd_fill, vram_dout,
    output cpu_ack, cpu_rdata, cmd_ready, busy, done, vram_wr, vram_addr, vram_din
  );
endinterface

// File: rtl/vram_port_ctrl.sv
// VRAM port-A controller: shares the port between CPU load/store and the CLEAR/SCROLL engine.
// The CPU wins any cycle it may use; the engine advances only in cycles the CPU leaves free.
module vram_port_ctrl #(
  parameter int DATA = 8,
  parameter int ADDR = 13,
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input logic clk,
  input logic rst_n,
  vram_port_ctrl_if.slave bus
);

  localparam int MEM = COLS * ROWS;
  localparam logic [ADDR-1:0] LAST_WORD = ADDR'(MEM - 1);
  localparam logic [ADDR-1:0] LAST_MOVE = ADDR'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR-1:0] ROW_STEP  = ADDR'(COLS);

  typedef enum logic [2:0] {IDLE, CLR, SCR_RD, SCR_WR, SCR_FILL} state_t;

  state_t          state, state_nx;
  logic [ADDR-1:0] ptr, ptr_nx;
  logic [DATA-1:0] fill, fill_nx;
  logic            ack;
  logic            done_q, done_nx;
  logic            grant;
  logic            eng_use, eng_wr;
  logic [ADDR-1:0] eng_addr;
  logic [DATA-1:0] eng_din;

  // SCR_WR consumes the word read one cycle earlier, so the CPU is locked out of it.
  assign grant = rst_n && bus.cpu_req && !ack && (state != SCR_WR);

  assign bus.cpu_ack   = ack;
  assign bus.cpu_rdata = bus.vram_dout & {DATA{ack}};
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      fill   <= '0;
      ack    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      fill   <= fill_nx;
      ack    <= grant;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    fill_nx  = fill;
    done_nx  = 1'b0;
    eng_use  = 1'b0;
    eng_wr   = 1'b0;
    eng_addr = '0;
    eng_din  = '0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          ptr_nx   = '0;
          fill_nx  = bus.cmd_fill;
          state_nx = bus.cmd_op ? SCR_RD : CLR;
        end
      end
      CLR, SCR_FILL: begin
        eng_use  = 1'b1;
        eng_wr   = 1'b1;
        eng_addr = ptr;
        eng_din  = fill;
        if (!grant) begin
          ptr_nx = ptr + 1'b1;
          if (ptr == LAST_WORD) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      SCR_RD: begin
        // Source is one row below; it never passes the last word, so no carry is possible.
        eng_use  = 1'b1;
        eng_addr = ptr + ROW_STEP;
        if (!grant) state_nx = SCR_WR;
      end
      SCR_WR: begin
        eng_use  = 1'b1;
        eng_wr   = 1'b1;
        eng_addr = ptr;
        eng_din  = bus.vram_dout;
        ptr_nx   = ptr + 1'b1;
        state_nx = (ptr == LAST_MOVE) ? SCR_FILL : SCR_RD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.vram_wr   = 1'b0;
    bus.vram_addr = '0;
    bus.vram_din  = '0;
    if (grant) begin
      bus.vram_wr   = bus.cpu_we;
      bus.vram_addr = bus.cpu_addr;
      bus.vram_din  = bus.cpu_wdata;
    end else if (rst_n && eng_use) begin
      bus.vram_wr   = eng_wr;
      bus.vram_addr = eng_addr;
      bus.vram_din  = eng_din;
    end
  end

endmodule

// File: tb/tb_vram_port_ctrl.sv
// Bench for vram_port_ctrl: behavioural VRAM plus a screen-level reference model,
// table-driven CPU accesses, CLEAR/SCROLL corner sequences and a randomized phase.
module tb_vram_port_ctrl;
  localparam int DATA = 8;
  localparam int ADDR = 13;
  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int MEM  = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vram_port_ctrl_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

  vram_port_ctrl #(.DATA(DATA), .ADDR(ADDR), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Behavioural dual-port VRAM (port A only): 1-cycle read, write at the addressing edge.
  logic [DATA-1:0] vram [MEM];
  logic [DATA-1:0] ram_q;
  logic            do_preload = 1'b0;
  logic [DATA-1:0] preload_seed = '0;
  int              oor_cnt = 0;

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < MEM; i++) vram[i] <= DATA'(i) + preload_seed;
    end else if (bus.vram_wr && int'(bus.vram_addr) < MEM) begin
      vram[bus.vram_addr] <= bus.vram_din;
    end
    ram_q <= (int'(bus.vram_addr) < MEM) ? vram[bus.vram_addr] : '0;
  end
  assign bus.vram_dout = ram_q;

  always @(negedge clk) begin
    if (int'(bus.vram_addr) >= MEM) oor_cnt <= oor_cnt + 1;
  end

  logic [DATA-1:0] ref_mem [MEM];
  int total = 0;
  int bad = 0;

  typedef struct {
    bit              we;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] wdata;
    logic [DATA-1:0] exp_rdata;
  } vec_t;
  vec_t vecs [8];

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_fill  = '0;
  endtask

  task automatic ref_clear(input logic [DATA-1:0] f);
    for (int i = 0; i < MEM; i++) ref_mem[i] = f;
  endtask

  // Screen moves up one row for the first 'moved' words; a full scroll also fills the bottom row.
  task automatic ref_scroll(input logic [DATA-1:0] f, input int moved);
    for (int i = 0; i < moved; i++) ref_mem[i] = ref_mem[i + COLS];
    if (moved == MEM - COLS) for (int i = MEM - COLS; i < MEM; i++) ref_mem[i] = f;
  endtask

  task automatic preload(input logic [DATA-1:0] s);
    tick();
    preload_seed = s;
    do_preload   = 1'b1;
    tick();
    do_preload   = 1'b0;
    for (int i = 0; i < MEM; i++) ref_mem[i] = DATA'(i) + s;
  endtask

  task automatic check_screen(input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < MEM; i++) if (vram[i] !== ref_mem[i]) nbad++;
    check_output(name, nbad, 0);
  endtask

  task automatic cpu_access(input bit we, input logic [ADDR-1:0] addr,
                            input logic [DATA-1:0] wdata, output logic [DATA-1:0] rdata);
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    #1;
    check_output("grant_wr", int'(bus.vram_wr), int'(we));
    check_output("grant_addr", int'(bus.vram_addr), int'(addr));
    check_output("grant_ack_low", int'(bus.cpu_ack), 0);
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    #1;
    check_output("ack_pulse", int'(bus.cpu_ack), 1);
    rdata = bus.cpu_rdata;
    tick();
    #1;
    check_output("ack_drop", int'(bus.cpu_ack), 0);
    check_output("rdata_masked", int'(bus.cpu_rdata), 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [DATA-1:0] rd;
    cpu_access(v.we, v.addr, v.wdata, rd);
    if (v.we) ref_mem[v.addr] = v.wdata;
    else check_output("table_rdata", int'(rd), int'(v.exp_rdata));
  endtask

  // mode 0: no CPU traffic, 1: reads held high throughout, 2: random reads.
  task automatic run_cmd(input bit op, input logic [DATA-1:0] fill, input int mode, input int limit,
                         output int done_at, output int busy_cnt, output int alt_err);
    bit prev_ack;
    done_at = -1; busy_cnt = 0; alt_err = 0; prev_ack = 1'b0;
    tick();
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_fill = fill;
    if (mode == 1) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = ADDR'(MEM - 1);
    end
    #1;
    check_output("cmd_ready_at_T", int'(bus.cmd_ready), 1);
    check_output("busy_at_T", int'(bus.busy), 0);
    for (int n = 1; n <= limit; n++) begin
      tick();
      bus.cmd_valid = 1'b0;
      if (mode == 2) begin
        if (bus.cpu_ack) bus.cpu_req = 1'b0;
        else if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
          bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
          bus.cpu_addr = ADDR'($urandom_range(0, MEM - 1));
        end
      end
      #1;
      if (mode == 1 && bus.cpu_ack == prev_ack) alt_err++;
      prev_ack = bus.cpu_ack;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at = n;
        break;
      end
    end
    check_output("busy_at_done", int'(bus.busy), 0);
    check_output("ready_at_done", int'(bus.cmd_ready), 1);
    bus.cpu_req = 1'b0;
    tick();
    #1;
    check_output("done_pulse_drop", int'(bus.done), 0);
    tick();
  endtask

  initial begin
    int done_at, busy_cnt, alt_err, found, extra_done;
    bit op;
    logic [DATA-1:0] f, rd, wd;
    logic [ADDR-1:0] a;
    bit we;

    vecs[0] = '{1'b1, 13'd100,  8'h41, 8'h00};
    vecs[1] = '{1'b0, 13'd100,  8'h00, 8'h41};
    vecs[2] = '{1'b1, 13'd0,    8'hFF, 8'h00};
    vecs[3] = '{1'b1, 13'd4799, 8'h5A, 8'h00};
    vecs[4] = '{1'b0, 13'd0,    8'h00, 8'hFF};
    vecs[5] = '{1'b0, 13'd4799, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 13'd100,  8'h00, 8'h00};
    vecs[7] = '{1'b0, 13'd100,  8'h00, 8'h00};

    // Reset held for 3 edges with both requesters active.
    rst_n = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'd5; bus.cpu_wdata = 8'h99;
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_fill = 8'h11;
    #1;
    check_output("rst_wr_pre_edge", int'(bus.vram_wr), 0);
    for (int c = 1; c <= 2; c++) begin
      tick();
      #1;
      check_output("rst_wr", int'(bus.vram_wr), 0);
      check_output("rst_ack", int'(bus.cpu_ack), 0);
      check_output("rst_busy", int'(bus.busy), 0);
    end
    tick();
    rst_n = 1'b1;
    drive_idle();
    #1;
    check_output("rel_cmd_ready", int'(bus.cmd_ready), 1);
    check_output("rel_busy", int'(bus.busy), 0);
    check_output("rel_ack", int'(bus.cpu_ack), 0);
    check_output("rel_done", int'(bus.done), 0);
    check_output("idle_addr", int'(bus.vram_addr), 0);
    check_output("idle_din", int'(bus.vram_din), 0);

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

    // CLEAR, uncontended.
    run_cmd(1'b0, 8'h20, 0, 6000, done_at, busy_cnt, alt_err);
    check_output("clear_done_at", done_at, 4801);
    check_output("clear_busy_cycles", busy_cnt, 4800);
    ref_clear(8'h20);
    check_screen("clear_screen");

    // SCROLL of a ramp, uncontended.
    preload(8'h00);
    run_cmd(1'b1, 8'h00, 0, 11000, done_at, busy_cnt, alt_err);
    check_output("scroll_done_at", done_at, 9521);
    check_output("scroll_busy_cycles", busy_cnt, 9520);
    check_output("scroll_word0", int'(vram[0]), 80);
    check_output("scroll_word4719", int'(vram[4719]), 8'hBF);
    check_output("scroll_word4720", int'(vram[4720]), 0);
    ref_scroll(8'h00, MEM - COLS);
    check_screen("scroll_screen");

    // CLEAR while the CPU reads continuously.
    run_cmd(1'b0, 8'h5C, 1, 10000, done_at, busy_cnt, alt_err);
    check_output("contend_ack_alternates", alt_err, 0);
    check_output("contend_done_bound", int'(done_at > 4801 && done_at <= 9601), 1);
    ref_clear(8'h5C);
    check_screen("contend_screen");

    // Reset in the SCR_WR cycle for ptr=1000, then a fresh CLEAR.
    preload(8'h33);
    tick();
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.cmd_fill = 8'hEE;
    #1;
    found = 0;
    for (int n = 1; n <= 3000; n++) begin
      tick();
      bus.cmd_valid = 1'b0;
      #1;
      if (bus.busy && !bus.vram_wr && int'(bus.vram_addr) == 1080) begin
        found = 1;
        break;
      end
    end
    check_output("abort_reached_ptr1000", found, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_output("abort_wr_blocked", int'(bus.vram_wr), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check_output("abort_busy", int'(bus.busy), 0);
    check_output("abort_ready", int'(bus.cmd_ready), 1);
    check_output("abort_wr", int'(bus.vram_wr), 0);
    extra_done = int'(bus.done);
    for (int n = 0; n < 5; n++) begin
      tick();
      #1;
      extra_done += int'(bus.done);
    end
    check_output("abort_no_done", extra_done, 0);
    ref_scroll(8'hEE, 1000);
    check_screen("abort_screen");
    run_cmd(1'b0, 8'h77, 0, 6000, done_at, busy_cnt, alt_err);
    check_output("post_abort_clear_done_at", done_at, 4801);
    ref_clear(8'h77);
    check_screen("post_abort_screen");

    // Randomized traffic against the screen model.
    preload(DATA'($urandom));
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ADDR'($urandom_range(0, MEM - 1));
      wd = DATA'($urandom);
      cpu_access(we, a, wd, rd);
      if (we) ref_mem[a] = wd;
      else check_output("rand_rdata", int'(rd), int'(ref_mem[a]));
    end
    op = 1'($urandom_range(0, 1));
    f  = DATA'($urandom);
    run_cmd(op, f, 2, 22000, done_at, busy_cnt, alt_err);
    check_output("rand_done_seen", int'(done_at > 0), 1);
    check_output("rand_busy_until_done", busy_cnt, done_at - 1);
    if (op) ref_scroll(f, MEM - COLS);
    else ref_clear(f);
    check_screen("rand_screen");
    for (int i = 0; i < 20; i++) begin
      a = ADDR'($urandom_range(0, MEM - 1));
      cpu_access(1'b0, a, '0, rd);
      check_output("rand_post_rdata", int'(rd), int'(ref_mem[a]));
    end

    check_output("addr_in_range", oor_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
